// File: rtl/inst_fetch_resp.sv
// -----------------------------------------------------------------------------
// inst_fetch_resp
//   Responder side of the instruction-fetch interface. Accepts a fetch address
//   from the PC stage and runs a variable-latency req/ack read against the
//   instruction memory. The fetched word goes to decode with a one-cycle valid
//   pulse. A jump kills the fetch that is in flight.
//
// Ports
//   clk, rst        clock (rising edge), synchronous active-low reset
//   pc_i, re_i      fetch address / fetch request from the PC stage
//   jump_flag_i     flush: kills the outstanding fetch; pc_i is stale that cycle
//   hold_flag_o     PC stage must hold while a live fetch is outstanding
//   hold_addr_o     address the PC stage re-presents after the hold (addr_q + 4)
//   mem_req_o       memory read request, held until ack or timeout
//   mem_addr_o      memory word address (addr_q)
//   mem_ack_i       memory data valid, qualifies mem_rdata_i
//   mem_rdata_i     memory read data
//   inst_o          fetched instruction (holds its value between pulses)
//   inst_addr_o     address of inst_o
//   inst_valid_o    one-cycle pulse: inst_o / inst_addr_o are valid
//   err_o           one-cycle pulse with inst_valid_o on timeout or misalign
// -----------------------------------------------------------------------------
module inst_fetch_resp #(
   parameter int                ADDR_W   = 32,
   parameter int                DATA_W   = 32,
   parameter int                TIMEOUT  = 16,
   parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(32'h00000013)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] pc_i,
   input  logic              re_i,
   input  logic              jump_flag_i,
   output logic              hold_flag_o,
   output logic [ADDR_W-1:0] hold_addr_o,
   output logic              mem_req_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   input  logic              mem_ack_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   output logic [DATA_W-1:0] inst_o,
   output logic [ADDR_W-1:0] inst_addr_o,
   output logic              inst_valid_o,
   output logic              err_o
);

   localparam int CNT_W = $clog2(TIMEOUT) + 1;

   typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              kill_q, kill_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] inst_q, inst_d;
   logic [ADDR_W-1:0] inst_addr_q, inst_addr_d;
   logic              valid_q, valid_d;
   logic              err_q, err_d;
   logic              timeout;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         kill_q      <= 1'b0;
         cnt_q       <= '0;
         inst_q      <= '0;
         inst_addr_q <= '0;
         valid_q     <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         kill_q      <= kill_d;
         cnt_q       <= cnt_d;
         inst_q      <= inst_d;
         inst_addr_q <= inst_addr_d;
         valid_q     <= valid_d;
         err_q       <= err_d;
      end
   end

   // Counter runs across WAIT and DRAIN, so a killed transaction still gets
   // the full TIMEOUT budget measured from the original request.
   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      kill_d      = kill_q;
      cnt_d       = cnt_q;
      inst_d      = inst_q;
      inst_addr_d = inst_addr_q;
      valid_d     = 1'b0;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            // A jump makes pc_i stale, so re_i is ignored that cycle.
            if (re_i && !jump_flag_i) begin
               if (pc_i[1:0] != 2'b00) begin
                  valid_d     = 1'b1;
                  err_d       = 1'b1;
                  inst_d      = NOP_INST;
                  inst_addr_d = pc_i;
               end else begin
                  addr_d  = pc_i;
                  cnt_d   = '0;
                  state_d = WAIT;
               end
            end
         end
         WAIT: begin
            if (mem_ack_i) begin
               state_d = IDLE;
               // Data arriving with a jump belongs to the flushed path.
               if (!kill_q && !jump_flag_i) begin
                  valid_d     = 1'b1;
                  inst_d      = mem_rdata_i;
                  inst_addr_d = addr_q;
               end
            end else if (timeout) begin
               state_d = IDLE;
               if (!jump_flag_i) begin
                  valid_d     = 1'b1;
                  err_d       = 1'b1;
                  inst_d      = NOP_INST;
                  inst_addr_d = addr_q;
               end
            end else if (jump_flag_i) begin
               // Memory cannot abort, so keep requesting but release the PC.
               kill_d  = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
               state_d = DRAIN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DRAIN: begin
            if (mem_ack_i || timeout) begin
               kill_d  = 1'b0;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            kill_d  = 1'b0;
            state_d = IDLE;
         end
      endcase
   end

   // Address outputs are zeroed when not meaningful, so reset shows all zeros.
   assign mem_req_o    = (state_q != IDLE);
   assign hold_flag_o  = (state_q == WAIT);
   assign mem_addr_o   = mem_req_o ? addr_q : '0;
   assign hold_addr_o  = hold_flag_o ? (addr_q + ADDR_W'(4)) : '0;
   assign inst_o       = inst_q;
   assign inst_addr_o  = inst_addr_q;
   assign inst_valid_o = valid_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_inst_fetch_resp.sv
module tb_inst_fetch_resp;

   localparam int          TIMEOUT = 16;
   localparam logic [31:0] NOP     = 32'h00000013;

   logic        clk;
   logic        rst;
   logic [31:0] pc_i;
   logic        re_i;
   logic        jump_flag_i;
   logic        hold_flag_o;
   logic [31:0] hold_addr_o;
   logic        mem_req_o;
   logic [31:0] mem_addr_o;
   logic        mem_ack_i;
   logic [31:0] mem_rdata_i;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;
   logic        inst_valid_o;
   logic        err_o;

   inst_fetch_resp #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .NOP_INST(NOP)
   ) dut (
      .clk(clk), .rst(rst), .pc_i(pc_i), .re_i(re_i), .jump_flag_i(jump_flag_i),
      .hold_flag_o(hold_flag_o), .hold_addr_o(hold_addr_o),
      .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .inst_o(inst_o), .inst_addr_o(inst_addr_o),
      .inst_valid_o(inst_valid_o), .err_o(err_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [31:0] addr;
      logic        err;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboard whenever the DUT presents an instruction.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (mon_en) begin
         checks++;
         if (err_o && !inst_valid_o) begin
            errors++;
            $display("FAIL err_without_valid: err_o=1 inst_valid_o=0 (cycle %0d)", cyc);
         end
         if (inst_valid_o) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_valid: inst_o=%h inst_addr_o=%h expected none (cycle %0d)",
                        inst_o, inst_addr_o, cyc);
            end else begin
               e = q.pop_front();
               chk("inst_o", inst_o, e.data);
               chk("inst_addr_o", inst_addr_o, e.addr);
               chk("err_o", {31'd0, err_o}, {31'd0, e.err});
               chk("valid_cycle", cyc, e.cyc);
            end
         end
      end
   end

   // One aligned fetch. The bench plays the memory: ack after `delay` request
   // cycles; jump_at (0 = none) is the request cycle carrying a jump.
   task automatic fetch(input logic [31:0] pc, input int delay, input int jump_at);
      int          end_k;
      bit          killed;
      bit          hold_exp;
      logic [31:0] rd;
      exp_t        e;
      rd     = '0;
      end_k  = (delay < TIMEOUT) ? delay : TIMEOUT;
      killed = (jump_at >= 1) && (jump_at <= end_k);
      re_i = 1'b1; pc_i = pc; jump_flag_i = 1'b0; mem_ack_i = 1'b0;
      @(posedge clk); #1;
      for (int k = 1; k <= end_k; k++) begin
         hold_exp = !((jump_at >= 1) && (k > jump_at));
         chk("mem_req_o", {31'd0, mem_req_o}, 32'd1);
         chk("mem_addr_o", mem_addr_o, pc);
         chk("hold_flag_o", {31'd0, hold_flag_o}, {31'd0, hold_exp});
         if (hold_exp) chk("hold_addr_o", hold_addr_o, pc + 32'd4);
         // Requests during an outstanding fetch must be ignored.
         re_i        = 1'($urandom_range(0, 1));
         pc_i        = $urandom;
         mem_rdata_i = $urandom;
         mem_ack_i   = (k == delay);
         if (k == jump_at)                        jump_flag_i = 1'b1;
         else if ((jump_at >= 1) && (k > jump_at)) jump_flag_i = 1'($urandom_range(0, 1));
         else                                     jump_flag_i = 1'b0;
         if (k == delay) rd = mem_rdata_i;
         @(posedge clk); #1;
      end
      re_i = 1'b0; mem_ack_i = 1'b0; jump_flag_i = 1'b0;
      chk("mem_req_end", {31'd0, mem_req_o}, 32'd0);
      chk("hold_flag_end", {31'd0, hold_flag_o}, 32'd0);
      if (!killed) begin
         e.data = (delay <= TIMEOUT) ? rd : NOP;
         e.addr = pc;
         e.err  = (delay > TIMEOUT);
         e.cyc  = cyc;
         q.push_back(e);
      end
   endtask

   task automatic misalign(input logic [31:0] pc);
      exp_t e;
      re_i = 1'b1; pc_i = pc; jump_flag_i = 1'b0;
      @(posedge clk); #1;
      re_i = 1'b0;
      chk("misalign_no_req", {31'd0, mem_req_o}, 32'd0);
      e.data = NOP; e.addr = pc; e.err = 1'b1; e.cyc = cyc;
      q.push_back(e);
   endtask

   task automatic jump_idle(input logic [31:0] pc);
      re_i = 1'b1; pc_i = pc; jump_flag_i = 1'b1;
      @(posedge clk); #1;
      re_i = 1'b0; jump_flag_i = 1'b0;
      chk("jump_idle_no_req", {31'd0, mem_req_o}, 32'd0);
      chk("jump_idle_no_hold", {31'd0, hold_flag_o}, 32'd0);
   endtask

   initial begin
      logic [31:0] pc;
      int          sel;
      rst = 1'b0; re_i = 1'b1; pc_i = 32'h0000_0040; jump_flag_i = 1'b0;
      mem_ack_i = 1'b0; mem_rdata_i = 32'hDEAD_BEEF;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
      chk("rst_hold_flag", {31'd0, hold_flag_o}, 32'd0);
      chk("rst_hold_addr", hold_addr_o, 32'd0);
      chk("rst_mem_addr", mem_addr_o, 32'd0);
      chk("rst_inst", inst_o, 32'd0);
      chk("rst_inst_addr", inst_addr_o, 32'd0);
      chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      mon_en = 1'b1;
      rst = 1'b1;

      fetch(32'h0000_0000, 1, 0);
      fetch(32'h0000_0100, 1, 0);
      fetch(32'h0000_0100, 5, 0);
      fetch(32'h0000_0104, 2, 0);            // accepted in the valid cycle
      fetch(32'h0000_0180, 5, 2);            // killed, drains on late ack
      fetch(32'h0000_0200, 3, 0);
      fetch(32'h0000_0300, 100, 0);          // timeout
      misalign(32'h0000_0102);
      fetch(32'hFFFF_FFFC, 3, 0);            // hold_addr wraps to 0
      fetch(32'h0000_0400, 4, 4);            // ack coincides with jump
      fetch(32'h0000_0500, 100, 3);          // killed, drain times out
      jump_idle(32'h0000_0600);

      // Reset in the middle of a fetch abandons it.
      re_i = 1'b1; pc_i = 32'h0000_0700;
      @(posedge clk); #1;
      re_i = 1'b0;
      chk("pre_rst_req", {31'd0, mem_req_o}, 32'd1);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      chk("mid_rst_req", {31'd0, mem_req_o}, 32'd0);
      chk("mid_rst_hold", {31'd0, hold_flag_o}, 32'd0);
      fetch(32'h0000_0800, 2, 0);

      for (int n = 0; n < 200; n++) begin
         sel = $urandom_range(0, 9);
         pc  = $urandom & 32'hFFFF_FFFC;
         if (sel == 0) begin
            pc[1:0] = 2'($urandom_range(1, 3));
            misalign(pc);
         end else if (sel == 1) begin
            jump_idle(pc);
         end else if (sel == 2) begin
            @(posedge clk); #1;
         end else begin
            fetch(pc, $urandom_range(1, 20),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0);
         end
      end

      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d expected instructions never seen", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
